// File: rtl/unnrzi_unstuff.sv
// USB receive NRZI decoder with bit-unstuffing and packet-boundary forwarding.
// Latency: 1 cycle from input strobe to registered output strobe.
// Backpressure: none; every input strobe is consumed, stuff bits yield no output.
// Optional stuff-violation checking is enabled by defining UNNRZI_STUFF_CHECK_EN.
module unnrzi_unstuff #(
  parameter int   STUFF_LEN  = 6,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_b,
  input  logic bstr_in,
  input  logic bstr_in_ready,
  input  logic in_done,
  output logic bstr_out,
  output logic bstr_out_ready,
  output logic out_done,
  output logic stuff_err
);

  localparam int             CW      = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STUFF_LEN);

`ifdef UNNRZI_STUFF_CHECK_EN
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
`else
  typedef enum logic {IDLE, RUN} state_t;
`endif

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] ones, ones_nxt;
  logic          dec;
  logic          slot;
  logic          emit;
`ifdef UNNRZI_STUFF_CHECK_EN
  logic          viol;
`endif

  // NRZI: an unchanged line level means a one
  assign dec  = (bstr_in == last);
  // the bit following a full run of ones is the stuff bit
  assign slot = (ones == CNT_MAX);

  // next-state, reference, run counter and emit decision
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    ones_nxt  = ones;
    emit      = 1'b0;
`ifdef UNNRZI_STUFF_CHECK_EN
    viol      = 1'b0;
`endif
    if (bstr_in_ready) begin
      last_nxt = bstr_in;
      if (slot || !dec) begin
        ones_nxt = '0;
      end else begin
        ones_nxt = ones + CW'(1);
      end
      case (state)
        IDLE: begin
          state_nxt = RUN;
          emit      = !slot;
        end
        RUN: begin
          emit = !slot;
`ifdef UNNRZI_STUFF_CHECK_EN
          // a one in the stuff slot means the transmitter broke the rule
          if (slot && dec) begin
            viol      = 1'b1;
            state_nxt = ERR;
          end
`endif
        end
`ifdef UNNRZI_STUFF_CHECK_EN
        // errored packet: track the line but emit nothing until packet end
        ERR: emit = 1'b0;
`endif
        default: emit = 1'b0;
      endcase
    end
    // packet end wins over everything, after the coincident bit was decoded
    if (in_done) begin
      last_nxt  = IDLE_LEVEL;
      ones_nxt  = '0;
      state_nxt = IDLE;
    end
  end

  // state, NRZI reference and ones-run registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      last  <= IDLE_LEVEL;
      ones  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      ones  <= ones_nxt;
    end
  end

  // registered output strobe, data and packet-end pulse
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bstr_out       <= 1'b0;
      bstr_out_ready <= 1'b0;
      out_done       <= 1'b0;
    end else begin
      bstr_out       <= emit & dec;
      bstr_out_ready <= emit;
      out_done       <= in_done;
    end
  end

`ifdef UNNRZI_STUFF_CHECK_EN
  // one-cycle error pulse for the violating stuff bit
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stuff_err <= 1'b0;
    end else begin
      stuff_err <= viol;
    end
  end
`else
  assign stuff_err = 1'b0;
`endif

endmodule

// File: tb/tb_unnrzi_unstuff.sv
// Randomised and directed bench for unnrzi_unstuff with a scoreboard model.
// Latency: expected outputs are scheduled for the cycle after each input.
// Backpressure: none; the monitor checks every output cycle against the queue.
module tb_unnrzi_unstuff;

  localparam int   STUFF_LEN  = 6;
  localparam logic IDLE_LEVEL = 1'b1;
`ifdef UNNRZI_STUFF_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic bstr_in = 1'b0;
  logic bstr_in_ready = 1'b0;
  logic in_done = 1'b0;
  logic bstr_out;
  logic bstr_out_ready;
  logic out_done;
  logic stuff_err;

  unnrzi_unstuff #(.STUFF_LEN(STUFF_LEN), .IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .bstr_in       (bstr_in),
    .bstr_in_ready (bstr_in_ready),
    .in_done       (in_done),
    .bstr_out      (bstr_out),
    .bstr_out_ready(bstr_out_ready),
    .out_done      (out_done),
    .stuff_err     (stuff_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic emit;
    logic val;
    logic done;
    logic err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference model state: line level seen last, length of the current ones run,
  // and whether the current packet has already been declared broken
  logic m_last = IDLE_LEVEL;
  int   m_ones = 0;
  bit   m_bad  = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_last = IDLE_LEVEL;
    m_ones = 0;
    m_bad  = 1'b0;
  endtask

  // drive one cycle of input and schedule what the DUT must show next cycle
  task automatic step(input logic line, input logic vld, input logic done);
    exp_t e;
    logic d;
    @(negedge clk);
    bstr_in       = line;
    bstr_in_ready = vld;
    in_done       = done;
    e.cyc  = cyc + 1;
    e.emit = 1'b0;
    e.val  = 1'b0;
    e.done = done;
    e.err  = 1'b0;
    if (vld) begin
      d = (line == m_last);
      m_last = line;
      if (m_ones == STUFF_LEN) begin
        // stuff slot: never forwarded; a one here is a violation when checking
        if (d && CHECK_EN && !m_bad) begin
          e.err = 1'b1;
          m_bad = 1'b1;
        end
        m_ones = 0;
      end else begin
        e.emit = !m_bad;
        e.val  = d;
        m_ones = d ? m_ones + 1 : 0;
      end
    end
    if (done) model_reset();
    if (e.emit || e.done || e.err) q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic bits(input logic [31:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(v[i], 1'b1, 1'b0);
      if (gap > 0) idle(gap);
    end
  endtask

  // monitor: every active output cycle must match the head of the queue
  always @(negedge clk) begin
    if (rst_b) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_output: nothing seen, expected emit=%b val=%b done=%b err=%b at cycle %0d",
                 q[0].emit, q[0].val, q[0].done, q[0].err, q[0].cyc);
        void'(q.pop_front());
      end
      if (bstr_out_ready || out_done || stuff_err) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got rdy=%b out=%b done=%b err=%b, expected idle (cycle %0d)",
                   bstr_out_ready, bstr_out, out_done, stuff_err, cyc);
        end else begin
          chk("out_ready", bstr_out_ready, q[0].emit);
          if (q[0].emit) chk("out_bit", bstr_out, q[0].val);
          chk("out_done", out_done, q[0].done);
          chk("stuff_err", stuff_err, q[0].err);
          void'(q.pop_front());
        end
      end
    end
  end

  logic rl;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out", bstr_out, 1'b0);
    chk("rst_ready", bstr_out_ready, 1'b0);
    chk("rst_done", out_done, 1'b0);
    chk("rst_err", stuff_err, 1'b0);
    rst_b = 1'b1;

    // basic decode: line 1,1,0,0,1 -> 1,1,0,1,0
    bits(32'b11001, 5, 0);
    step(1'b0, 1'b0, 1'b1);
    idle(2);

    // stuff removal: six ones, stuff 0 dropped, then 0 decodes to 1
    bits(32'b11111100, 8, 0);
    step(1'b0, 1'b0, 1'b1);
    idle(2);

    // stuff violation: seven ones then more bits, then packet end
    bits(32'b1111111010, 10, 0);
    step(1'b0, 1'b0, 1'b1);
    bits(32'b11001, 5, 0);
    step(1'b0, 1'b0, 1'b1);

    // strobe gaps of 3 cycles between bits
    bits(32'b11001, 5, 3);
    step(1'b0, 1'b0, 1'b1);

    // packet end coincident with final bit on line 0, then new packet from J
    bits(32'b101, 3, 0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);

    // violation coincident with packet end
    bits(32'b111111, 6, 0);
    step(1'b1, 1'b1, 1'b1);

    // packet end while idle
    step(1'b0, 1'b0, 1'b1);
    idle(2);

    // reset mid-run after four ones
    bits(32'b1111, 4, 0);
    @(posedge clk);
    #2;
    chk("pre_rst_ready", bstr_out_ready, 1'b1);
    rst_b = 1'b0;
    bstr_in_ready = 1'b0;
    in_done = 1'b0;
    #1;
    chk("mid_rst_out", bstr_out, 1'b0);
    chk("mid_rst_ready", bstr_out_ready, 1'b0);
    chk("mid_rst_done", out_done, 1'b0);
    chk("mid_rst_err", stuff_err, 1'b0);
    q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    bits(32'b11111101, 8, 0);
    step(1'b1, 1'b0, 1'b1);

    // random traffic biased toward long runs of ones
    rl = IDLE_LEVEL;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) rl = ~rl;
      step(rl, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
    end
    step(1'b0, 1'b0, 1'b1);
    idle(4);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never appeared, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
